reset_clock_manager: RTL and testbench
======================================

Name: reset_clock_manager

Overview:
- Board-level reset and clock-enable generator for the Baby Risco 5 FPGA tops.
- Extends the fixed boot-reset counter and single button reset into one block:
  - power-on hold
  - N debounced reset-request channels
  - post-release reset stretch
  - reset-cause capture
  - a parametrised clock-enable divider in place of a toggled clock
- Sits between the board clock buffer and the SoC; drives the SoC reset and the clock enable.

Parameters:
- CLK_DIV, 2, clk_en period in clk cycles (>=1).
- POR_CYCLES, 20, cycles reset_o is held after `reset` deasserts (>=1).
- NUM_SOURCES, 2, number of external reset-request channels (>=1).
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples needed to change a debounced level (>=1).
- STRETCH_CYCLES, 16, cycles reset_o is held after all requests release (>=1).
- WDT_CYCLES, 1000000, watchdog timeout in clk cycles; used only with WATCHDOG_EN.

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high; forces the POR state.
- rst_req  input  NUM_SOURCES  raw asynchronous active-high reset requests (buttons, debug).
- wdt_kick  input  1  watchdog restart strobe, active-high, one cycle.
- reset_o  output  1  registered active-high system reset.
- clk_en  output  1  one-cycle enable pulse every CLK_DIV cycles.
- reset_cause  output  NUM_SOURCES+2  bit0 = POR, bits[NUM_SOURCES:1] = rst_req channels, MSB = watchdog.

Behaviour:
- Counter widths are $clog2(max value + 1); no wrap-around is possible.
- While `reset`=1 (any state, including mid-operation):
  - state <= POR, all counters cleared, synchronizers and debounced levels cleared.
  - reset_o=1, clk_en=0, reset_cause=0...01.
- Input path, per channel:
  - 2-flop synchronizer, then a debounce counter.
  - The counter increments while the synchronized sample differs from the debounced level and clears when they match.
  - The debounced level flips on the edge where the counter would reach DEBOUNCE_CYCLES.
  - Pulses shorter than DEBOUNCE_CYCLES cycles are ignored.
- Latency: rst_req first sampled high at edge N and held → reset_o high after edge N+DEBOUNCE_CYCLES+3.
- FSM states:
  - POR:
    - reset_o=1; counts cycles after `reset` falls.
    - After POR_CYCLES cycles → HOLD if any debounced level is high, else RUN.
  - RUN:
    - reset_o=0.
    - Any debounced level high → HOLD. reset_cause is replaced by the mask of channels high that cycle; the POR bit clears.
  - HOLD:
    - reset_o=1.
    - Stays while any debounced level is high. Newly high channels OR into reset_cause.
    - All low → STRETCH with the counter cleared.
  - STRETCH:
    - reset_o=1; after STRETCH_CYCLES cycles → RUN.
    - A debounced level going high → HOLD, cause ORed in, counter cleared.
- reset_o is registered from the next-state decode: high from the edge the state enters POR/HOLD/STRETCH, low from the edge it enters RUN.
- clk_en divider:
  - Divider counter held at 0 and clk_en=0 while reset_o=1.
  - Otherwise the counter runs 0..CLK_DIV-1 and clk_en=1 when counter==CLK_DIV-1.
  - First pulse lands CLK_DIV cycles after reset_o falls.
  - CLK_DIV=1 → clk_en constant 1 while reset_o=0.
- reset_cause is held stable in RUN so firmware can read it after boot.

Optional Feature:
- Macro: WATCHDOG_EN.
- Defined:
  - Watchdog counter increments in RUN only and clears on wdt_kick or in any other state.
  - On reaching WDT_CYCLES → STRETCH with reset_cause = watchdog bit only (MSB=1, others 0).
  - A kick on the timeout cycle wins: no reset.
- Undefined: no counter is built, wdt_kick is ignored, reset_cause MSB is tied 0; the port list is unchanged.

Test Plan:
- Defaults; `reset`=1 for 3 cycles, then 0:
  - reset_o=1 during reset and for exactly 20 further cycles.
  - reset_cause=4'b0001.
  - clk_en first pulses 2 cycles after reset_o falls, then every 2nd cycle.
- In RUN, rst_req[1] high for 3 cycles → reset_o stays 0, reset_cause unchanged, clk_en cadence unbroken.
- In RUN, rst_req[0] first sampled high at edge N, held 10 cycles:
  - reset_o high after edge N+7.
  - Held through release debounce plus 16 stretch cycles.
  - reset_cause=4'b0010.
- During STRETCH from the previous case, rst_req[1] held 6 cycles → back to HOLD, full 16-cycle stretch restarts after release, reset_cause=4'b0110.
- `reset` pulsed 1 cycle mid-STRETCH → POR, reset_o held 20 cycles after `reset` falls, reset_cause=4'b0001.
- WATCHDOG_EN, WDT_CYCLES=50:
  - No kicks → reset_o rises after 50 RUN cycles, stays 16 cycles, reset_cause=4'b1000.
  - wdt_kick every 40 cycles → reset_o never rises over 1000 cycles.

Source files
------------

// File: rtl/reset_clock_manager.sv
// Board reset / clock-enable generator: power-on hold, debounced reset requests, release stretch,
// reset-cause capture and a clock-enable divider. Optional watchdog when WATCHDOG_EN is defined.
module reset_clock_manager #(
    parameter int CLK_DIV         = 2,
    parameter int POR_CYCLES      = 20,
    parameter int NUM_SOURCES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STRETCH_CYCLES  = 16,
    parameter int WDT_CYCLES      = 1000000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SOURCES-1:0] rst_req,
    input  logic                   wdt_kick,
    output logic                   reset_o,
    output logic                   clk_en,
    output logic [NUM_SOURCES+1:0] reset_cause
);
    localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CNT_MAX = (POR_CYCLES > STRETCH_CYCLES) ? POR_CYCLES : STRETCH_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DIV_W   = $clog2(CLK_DIV + 1);

    localparam logic [DEB_W-1:0] DEB_LAST     = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] POR_LAST     = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {ST_POR, ST_RUN, ST_HOLD, ST_STRETCH} state_t;

    state_t                   state_reg;
    logic [CNT_W-1:0]         cnt_reg;
    logic                     reset_o_reg;
    logic [NUM_SOURCES+1:0]   cause_reg;
    logic [NUM_SOURCES-1:0]   level_vec;
    logic [NUM_SOURCES-1:0]   req_mask_reg;
    logic [DIV_W-1:0]         div_cnt_reg;
    logic                     clk_en_reg;
    logic                     wdt_expire;

    // Per-channel synchronizer and debouncer.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SOURCES; gi++) begin : g_deb
            logic             s1_reg;
            logic             s2_reg;
            logic             level_reg;
            logic [DEB_W-1:0] deb_cnt_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    s1_reg      <= 1'b0;
                    s2_reg      <= 1'b0;
                    level_reg   <= 1'b0;
                    deb_cnt_reg <= '0;
                end else begin
                    s1_reg <= rst_req[gi];
                    s2_reg <= s1_reg;
                    if (s2_reg == level_reg) begin
                        deb_cnt_reg <= '0;
                    end else if (deb_cnt_reg == DEB_LAST) begin
                        level_reg   <= s2_reg;
                        deb_cnt_reg <= '0;
                    end else begin
                        deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
                    end
                end
            end

            assign level_vec[gi] = level_reg;
        end
    endgenerate

    // Registered copy of the debounced levels so the FSM decodes from a single flop stage.
    always_ff @(posedge clk) begin
        if (reset) req_mask_reg <= '0;
        else       req_mask_reg <= level_vec;
    end

`ifdef WATCHDOG_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);
    logic [WDT_W-1:0] wdt_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset || state_reg != ST_RUN || wdt_kick || wdt_expire) wdt_cnt_reg <= '0;
        else                                                         wdt_cnt_reg <= wdt_cnt_reg + WDT_W'(1);
    end

    // A kick in the timeout cycle suppresses the expiry.
    assign wdt_expire = (state_reg == ST_RUN) && !wdt_kick && (wdt_cnt_reg == WDT_LAST);
`else
    logic unused_wdt;
    assign unused_wdt = wdt_kick ^ (WDT_CYCLES == 0);
    assign wdt_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_POR;
            cnt_reg     <= '0;
            reset_o_reg <= 1'b1;
            cause_reg   <= (NUM_SOURCES + 2)'(1);
        end else begin
            case (state_reg)
                ST_POR: begin
                    if (cnt_reg == POR_LAST) begin
                        cnt_reg <= '0;
                        if (|req_mask_reg) begin
                            state_reg <= ST_HOLD;
                            cause_reg <= cause_reg | {1'b0, req_mask_reg, 1'b0};
                        end else begin
                            state_reg   <= ST_RUN;
                            reset_o_reg <= 1'b0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (|req_mask_reg) begin
                        state_reg   <= ST_HOLD;
                        reset_o_reg <= 1'b1;
                        cause_reg   <= {1'b0, req_mask_reg, 1'b0};
                    end else if (wdt_expire) begin
                        state_reg   <= ST_STRETCH;
                        cnt_reg     <= '0;
                        reset_o_reg <= 1'b1;
                        cause_reg   <= {1'b1, {(NUM_SOURCES + 1){1'b0}}};
                    end
                end
                ST_HOLD: begin
                    cause_reg <= cause_reg | {1'b0, req_mask_reg, 1'b0};
                    if (!(|req_mask_reg)) begin
                        state_reg <= ST_STRETCH;
                        cnt_reg   <= '0;
                    end
                end
                default: begin
                    if (|req_mask_reg) begin
                        state_reg <= ST_HOLD;
                        cnt_reg   <= '0;
                        cause_reg <= cause_reg | {1'b0, req_mask_reg, 1'b0};
                    end else if (cnt_reg == STRETCH_LAST) begin
                        state_reg   <= ST_RUN;
                        cnt_reg     <= '0;
                        reset_o_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || reset_o_reg) begin
            div_cnt_reg <= '0;
            clk_en_reg  <= 1'b0;
        end else begin
            div_cnt_reg <= (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + DIV_W'(1);
            clk_en_reg  <= (div_cnt_reg == DIV_LAST);
        end
    end

    // Masking with reset_o keeps clk_en low on the edge reset rises; CLK_DIV=1 bypasses the pipeline.
    assign clk_en      = !reset_o_reg && ((CLK_DIV == 1) || clk_en_reg);
    assign reset_o     = reset_o_reg;
    assign reset_cause = cause_reg;

endmodule

// File: tb/tb_reset_clock_manager.sv
// Directed bench for reset_clock_manager: POR, debounce, hold/stretch, cause capture, clk_en cadence,
// and the watchdog when WATCHDOG_EN is defined.
module tb_reset_clock_manager;
`ifdef WATCHDOG_EN
    localparam int TB_WDT = 50;
`else
    localparam int TB_WDT = 1000000;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] rst_req;
    logic       wdt_kick;
    logic       reset_o;
    logic       clk_en;
    logic [3:0] reset_cause;

    int   total = 0;
    int   bad = 0;
    int   run_k = 0;
    bit   auto_kick = 1'b1;
    logic [3:0] exp_cause = 4'b0001;

    reset_clock_manager #(
        .CLK_DIV(2), .POR_CYCLES(20), .NUM_SOURCES(2), .DEBOUNCE_CYCLES(4),
        .STRETCH_CYCLES(16), .WDT_CYCLES(TB_WDT)
    ) dut (
        .clk(clk), .reset(reset), .rst_req(rst_req), .wdt_kick(wdt_kick),
        .reset_o(reset_o), .clk_en(clk_en), .reset_cause(reset_cause)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // RUN-state cycles: reset_o low, cause stable, clk_en on every second cycle after release.
    task automatic run_steps(input int n);
        for (int i = 0; i < n; i++) begin
            if (auto_kick) wdt_kick = (run_k % 20 == 19);
            step();
            run_k++;
            check("run_reset_o", 32'(reset_o), 32'h0);
            check("run_cause", 32'(reset_cause), 32'(exp_cause));
            check("run_clk_en", 32'(clk_en), 32'((run_k >= 2) && (run_k % 2 == 0)));
        end
    endtask

    task automatic hold_steps(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check("hold_reset_o", 32'(reset_o), 32'h1);
            check("hold_clk_en", 32'(clk_en), 32'h0);
        end
    endtask

    // Raise rst_req[0] for 10 sampled cycles from RUN; ends after its edge N+9.
    task automatic req0_pulse(input string tag);
        rst_req = 2'b01;
        run_steps(7);
        step();
        check({tag, "_rise"}, 32'(reset_o), 32'h1);
        check({tag, "_cause"}, 32'(reset_cause), 32'h2);
        exp_cause = 4'b0010;
        hold_steps(2);
        rst_req = 2'b00;
    endtask

    initial begin
        reset = 1'b1;
        rst_req = 2'b00;
        wdt_kick = 1'b0;

        step();
        check("rst_reset_o", 32'(reset_o), 32'h1);
        check("rst_clk_en", 32'(clk_en), 32'h0);
        check("rst_cause", 32'(reset_cause), 32'h1);
        step();
        step();
        reset = 1'b0;
        $display("step: reset released, expecting 20-cycle POR hold");
        hold_steps(19);
        step();
        check("por_release", 32'(reset_o), 32'h0);
        check("por_cause", 32'(reset_cause), 32'h1);
        check("por_clk_en0", 32'(clk_en), 32'h0);
        run_k = 0;
        run_steps(12);

        $display("step: 3-cycle glitch on rst_req[1] should be filtered");
        rst_req = 2'b10;
        run_steps(3);
        rst_req = 2'b00;
        run_steps(12);

        $display("step: rst_req[0] held 10 cycles, full stretch");
        req0_pulse("req0");
        hold_steps(23);
        step();
        check("req0_release", 32'(reset_o), 32'h0);
        check("req0_cause_run", 32'(reset_cause), 32'h2);
        run_k = 0;
        run_steps(6);

        $display("step: rst_req[1] during stretch restarts hold");
        req0_pulse("req0b");
        hold_steps(10);
        rst_req = 2'b10;
        hold_steps(6);
        rst_req = 2'b00;
        step();
        check("stretch_cause_pre", 32'(reset_cause), 32'h2);
        step();
        check("stretch_cause_or", 32'(reset_cause), 32'h6);
        exp_cause = 4'b0110;
        hold_steps(21);
        step();
        check("restretch_release", 32'(reset_o), 32'h0);
        check("restretch_cause", 32'(reset_cause), 32'h6);
        run_k = 0;
        run_steps(4);

        $display("step: reset pulsed mid-stretch");
        req0_pulse("req0c");
        hold_steps(11);
        reset = 1'b1;
        step();
        check("midrst_reset_o", 32'(reset_o), 32'h1);
        check("midrst_cause", 32'(reset_cause), 32'h1);
        check("midrst_clk_en", 32'(clk_en), 32'h0);
        reset = 1'b0;
        exp_cause = 4'b0001;
        hold_steps(19);
        step();
        check("midrst_release", 32'(reset_o), 32'h0);
        run_k = 0;

        auto_kick = 1'b0;
        wdt_kick = 1'b0;
`ifdef WATCHDOG_EN
        $display("step: watchdog timeout without kicks");
        run_steps(49);
        step();
        check("wdt_fire", 32'(reset_o), 32'h1);
        check("wdt_cause", 32'(reset_cause), 32'h8);
        hold_steps(15);
        step();
        check("wdt_release", 32'(reset_o), 32'h0);
        check("wdt_cause_run", 32'(reset_cause), 32'h8);
        exp_cause = 4'b1000;
        run_k = 0;
`else
        $display("step: no watchdog built, long unkicked run");
        run_steps(200);
`endif

        $display("step: periodic kicks every 40 cycles for 1000 cycles");
        for (int k = 0; k < 25; k++) begin
            wdt_kick = 1'b1;
            run_steps(1);
            wdt_kick = 1'b0;
            run_steps(39);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
